// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and default widths for the fetch controller
package fetch_ctrl_pkg;

    localparam int IW_DEF = 10;
    localparam int LW_DEF = 5;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_ctrl_jump_lut.sv
// rtl/fetch_ctrl_jump_lut.sv - constant jump-target table with combinational read
module jump_lut
    import fetch_ctrl_pkg::*;
#(
    parameter int LW = LW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic [LW-1:0] i_idx,
    output logic [IW-1:0] o_target
);

    // Programmed entries; every other index reads back as zero
    always_comb begin
        o_target = '0;
        case (i_idx)
            LW'(1): o_target = IW'(2);
            LW'(2): o_target = '1;
            LW'(3): o_target = IW'(200);
            default: o_target = '0;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program-counter sequencer with run/done handshake and retired count
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int LW = LW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              HaltReq,
    input  logic              JumpEn,
    input  logic [LW-1:0]     JumpIdx,
    input  logic              BranchEn,
    input  logic signed [7:0] BranchOff,
    output logic [IW-1:0]     InstAddress,
    output logic              Busy,
    output logic              Done,
    output logic [CW-1:0]     InstCount
);

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_pc;
    logic [IW-1:0]   w_pc_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [IW-1:0]   w_jump_target;
    logic [IW-1:0]   w_off;

    jump_lut #(
        .LW (LW),
        .IW (IW)
    ) u_jump_lut (
        .i_idx    (JumpIdx),
        .o_target (w_jump_target)
    );

    // Branch offset sign-extended to PC width; the add then wraps modulo 2**IW
    assign w_off = {{(IW-8){BranchOff[7]}}, BranchOff};

    // State, PC and retired count registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, next-PC priority mux and saturating retire counter
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_pc_next = '0;
                if (Start) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
                    if (HaltReq) begin
                        w_state_next = ST_DONE;
                    end else if (JumpEn) begin
                        w_pc_next = w_jump_target;
                    end else if (BranchEn) begin
                        w_pc_next = r_pc + w_off;
                    end else begin
                        w_pc_next = r_pc + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!Start) begin
                    w_state_next = ST_IDLE;
                    w_pc_next    = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_pc_next    = '0;
            end
        endcase
    end

    assign InstAddress = r_pc;
    assign InstCount   = r_cnt;
    assign Busy        = (r_state == ST_RUN);
    assign Done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam int IW = 10;
    localparam int LW = 5;
    localparam int CW = 4;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic              Stall;
    logic              HaltReq;
    logic              JumpEn;
    logic [LW-1:0]     JumpIdx;
    logic              BranchEn;
    logic signed [7:0] BranchOff;
    logic [IW-1:0]     InstAddress;
    logic              Busy;
    logic              Done;
    logic [CW-1:0]     InstCount;

    int checks;
    int errors;

    fetch_ctrl #(
        .IW (IW),
        .LW (LW),
        .CW (CW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .HaltReq     (HaltReq),
        .JumpEn      (JumpEn),
        .JumpIdx     (JumpIdx),
        .BranchEn    (BranchEn),
        .BranchOff   (BranchOff),
        .InstAddress (InstAddress),
        .Busy        (Busy),
        .Done        (Done),
        .InstCount   (InstCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int pc, input int cnt, input int busy, input int done);
        chk({tag, "_pc"},   int'(InstAddress), pc);
        chk({tag, "_cnt"},  int'(InstCount),   cnt);
        chk({tag, "_busy"}, int'(Busy),        busy);
        chk({tag, "_done"}, int'(Done),        done);
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic clr_ctl();
        Stall     = 1'b0;
        HaltReq   = 1'b0;
        JumpEn    = 1'b0;
        JumpIdx   = '0;
        BranchEn  = 1'b0;
        BranchOff = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        Start  = 1'b1;
        clr_ctl();

        // reset state, Start already high while in reset
        tick();
        chk_all("reset", 0, 0, 0, 0);

        // release reset: Start high enters RUN on the first edge
        Reset = 1'b0;
        tick();
        chk_all("run_entry", 0, 0, 1, 0);

        // sequential fetch, Start dropped during RUN is ignored
        Start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("seq", i, i, 1, 0);
        end
        for (int i = 6; i <= 10; i++) tick();
        chk_all("pc10", 10, 10, 1, 0);

        // branch backwards from 10 by 3
        BranchEn = 1'b1; BranchOff = -8'sd3;
        tick();
        chk_all("br_m3", 7, 11, 1, 0);

        // jump to table[1]=2, then branch -5 wraps to 1021
        clr_ctl(); JumpEn = 1'b1; JumpIdx = 5'd1;
        tick();
        chk_all("jmp1", 2, 12, 1, 0);
        clr_ctl(); BranchEn = 1'b1; BranchOff = -8'sd5;
        tick();
        chk_all("br_wrap", 1021, 13, 1, 0);

        // jump beats branch: table[3]=200
        clr_ctl(); JumpEn = 1'b1; JumpIdx = 5'd3; BranchEn = 1'b1; BranchOff = 8'sd4;
        tick();
        chk_all("jmp_pri", 200, 14, 1, 0);

        // unprogrammed entry reads 0
        clr_ctl(); JumpEn = 1'b1; JumpIdx = 5'd9;
        tick();
        chk_all("jmp_unprog", 0, 15, 1, 0);

        // table[2]=1023, then PC+1 wraps to 0; counter saturated at 15
        clr_ctl(); JumpEn = 1'b1; JumpIdx = 5'd2;
        tick();
        chk_all("jmp_max", 1023, 15, 1, 0);
        clr_ctl();
        tick();
        chk_all("inc_wrap", 0, 15, 1, 0);
        for (int i = 1; i <= 4; i++) tick();
        chk_all("pc4", 4, 15, 1, 0);

        // stall wins over halt for 3 cycles
        Stall = 1'b1; HaltReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall", 4, 15, 1, 0);
        end

        // halt -> DONE with PC frozen
        Stall = 1'b0;
        tick();
        chk_all("halt", 4, 15, 0, 1);

        // DONE holds with Start high; control inputs ignored
        clr_ctl(); Start = 1'b1; JumpEn = 1'b1; JumpIdx = 5'd3;
        tick();
        chk_all("done_hold", 4, 15, 0, 1);

        // Start low returns to IDLE with PC 0
        clr_ctl(); Start = 1'b0;
        tick();
        chk_all("to_idle", 0, 15, 0, 0);
        tick();
        chk_all("idle_hold", 0, 15, 0, 0);

        // restart clears the counter
        Start = 1'b1;
        tick();
        chk_all("restart", 0, 0, 1, 0);
        Start = 1'b0;
        for (int i = 1; i <= 57; i++) tick();
        chk_all("pc57", 57, 15, 1, 0);

        // asynchronous reset between edges
        #2 Reset = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        #1 Reset = 1'b0;
        tick();
        chk_all("post_rst", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
